// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / hazard response bundle shared between the decode stage
// and fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
);
  logic                      id_valid;
  logic [NUM_SRC*5-1:0]      id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [4:0]                id_rd;
  logic                      id_regwrite;
  logic [1:0]                id_class;
  logic                      pipe_hold;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_class,
           pipe_hold, flush,
    input  stall, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_class,
           pipe_hold, flush,
    output stall, ex_fwd_sel
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks in-flight writes, decides forwarding in ID,
// raises load-use / multi-cycle stalls. Optional stall counters: FWD_STALL_STATS_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int MUL_LAT   = 3,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_unit_if.slave    bus
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [31:0]         stat_load_stalls,
  output logic [31:0]         stat_mul_stalls
`endif
);

  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_MUL  = 2'b10;

  logic            slot_valid [0:FWD_DEPTH];
  logic [4:0]      slot_rd    [0:FWD_DEPTH];
  logic [SELW-1:0] slot_ready [0:FWD_DEPTH];

  logic [4:0]              rs       [NUM_SRC];
  logic [NUM_SRC-1:0]      op_hit;
  logic [NUM_SRC-1:0]      op_stall;
  logic [SELW-1:0]         hit_idx  [NUM_SRC];
  logic [SELW-1:0]         op_sel   [NUM_SRC];
  logic [NUM_SRC*SELW-1:0] sel_next;
  logic [NUM_SRC*SELW-1:0] sel_q;
  logic                    stall_int;
  logic                    issue;
  logic [SELW-1:0]         issue_ready;

  // Descending scan so the youngest matching slot is the one left standing.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      rs[k]      = bus.id_rs[5*k +: 5];
      op_hit[k]  = 1'b0;
      hit_idx[k] = '0;
      for (int i = FWD_DEPTH; i >= 0; i--) begin
        if (bus.id_rs_used[k] && (rs[k] != 5'd0) && slot_valid[i] &&
            (slot_rd[i] == rs[k])) begin
          op_hit[k]  = 1'b1;
          hit_idx[k] = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_next = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      op_stall[k] = op_hit[k] &&
                    ((int'(hit_idx[k]) + 1) < int'(slot_ready[hit_idx[k]]));
      op_sel[k]   = '0;
      if (op_hit[k] && !op_stall[k] && (int'(hit_idx[k]) < FWD_DEPTH))
        op_sel[k] = SELW'(int'(hit_idx[k]) + 1);
      sel_next[k*SELW +: SELW] = op_sel[k];
    end
  end

  always_comb begin
    stall_int = bus.id_valid & ~bus.flush & (|op_stall);
    issue     = bus.id_valid & ~stall_int & ~bus.flush;
    case (bus.id_class)
      CLS_LOAD: issue_ready = SELW'(2);
      CLS_MUL:  issue_ready = SELW'(MUL_LAT);
      default:  issue_ready = SELW'(1);
    endcase
  end

  assign bus.stall      = stall_int;
  assign bus.ex_fwd_sel = sel_q;

  // The slot at FWD_DEPTH falls off the end; the register file already has it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= FWD_DEPTH; i++) begin
        slot_valid[i] <= 1'b0;
        slot_rd[i]    <= '0;
        slot_ready[i] <= '0;
      end
      sel_q <= '0;
    end else if (!bus.pipe_hold) begin
      for (int i = FWD_DEPTH; i >= 1; i--) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_rd[i]    <= slot_rd[i-1];
        slot_ready[i] <= slot_ready[i-1];
      end
      slot_valid[0] <= issue & bus.id_regwrite & (bus.id_rd != 5'd0);
      slot_rd[0]    <= bus.id_rd;
      slot_ready[0] <= issue_ready;
      sel_q         <= issue ? sel_next : '0;
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic            slot_load [0:FWD_DEPTH];
  logic            young_found;
  logic            young_is_load;
  logic [SELW-1:0] young_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= FWD_DEPTH; i++) slot_load[i] <= 1'b0;
    end else if (!bus.pipe_hold) begin
      for (int i = FWD_DEPTH; i >= 1; i--) slot_load[i] <= slot_load[i-1];
      slot_load[0] <= (bus.id_class == CLS_LOAD);
    end
  end

  // Operands stalling on the same slot see one producer; a load still wins ties.
  always_comb begin
    young_found   = 1'b0;
    young_is_load = 1'b0;
    young_idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (op_stall[k]) begin
        if (!young_found || (hit_idx[k] < young_idx)) begin
          young_found   = 1'b1;
          young_idx     = hit_idx[k];
          young_is_load = slot_load[hit_idx[k]];
        end else if (hit_idx[k] == young_idx) begin
          young_is_load = young_is_load | slot_load[hit_idx[k]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_load_stalls <= '0;
      stat_mul_stalls  <= '0;
    end else if (stall_int && !bus.pipe_hold) begin
      if (young_is_load) begin
        if (stat_load_stalls != 32'hFFFF_FFFF) stat_load_stalls <= stat_load_stalls + 32'd1;
      end else begin
        if (stat_mul_stalls != 32'hFFFF_FFFF) stat_mul_stalls <= stat_mul_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (defaults NUM_SRC=2,
// FWD_DEPTH=3, MUL_LAT=3); stat checks are compiled in with FWD_STALL_STATS_EN.
module tb_fwd_hazard_unit;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] MUL = 2'b10;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fwd_hazard_unit_if #(.NUM_SRC(2), .FWD_DEPTH(3)) bus ();

`ifdef FWD_STALL_STATS_EN
  logic [31:0] stat_load_stalls;
  logic [31:0] stat_mul_stalls;
`endif

  fwd_hazard_unit #(
    .NUM_SRC(2), .FWD_DEPTH(3), .MUL_LAT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FWD_STALL_STATS_EN
    ,
    .stat_load_stalls (stat_load_stalls),
    .stat_mul_stalls  (stat_mul_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] used, input logic [4:0] rd,
                                input logic wr, input logic [1:0] cls);
    bus.id_valid    = v;
    bus.id_rs       = {rs1, rs0};
    bus.id_rs_used  = used;
    bus.id_rd       = rd;
    bus.id_regwrite = wr;
    bus.id_class    = cls;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drain();
    bus.pipe_hold = 1'b0;
    bus.flush     = 1'b0;
    apply_stimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, ALU);
    repeat (4) tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.pipe_hold = 1'b0;
    bus.flush     = 1'b0;
    apply_stimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, ALU);
    #9;
    check_output("reset_stall", 32'(bus.stall), 32'd0);
    check_output("reset_sel", 32'(bus.ex_fwd_sel), 32'd0);
`ifdef FWD_STALL_STATS_EN
    check_output("reset_stat_load", stat_load_stalls, 32'd0);
    check_output("reset_stat_mul", stat_mul_stalls, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // ALU producer followed directly by its consumer
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, ALU);
    check_output("alu_prod_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("alu_prod_sel", 32'(bus.ex_fwd_sel), 32'd0);
    apply_stimulus(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, ALU);
    check_output("alu_b2b_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("alu_b2b_sel", 32'(bus.ex_fwd_sel), 32'h1);
    drain();

    // Load-use: one bubble, then forward from slot 2
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, LD);
    tick();
    apply_stimulus(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, ALU);
    check_output("ld_use_stall1", 32'(bus.stall), 32'd1);
    tick();
    check_output("ld_use_bubble_sel", 32'(bus.ex_fwd_sel), 32'd0);
    check_output("ld_use_stall2", 32'(bus.stall), 32'd0);
    tick();
    check_output("ld_use_sel", 32'(bus.ex_fwd_sel), 32'h2);
`ifdef FWD_STALL_STATS_EN
    check_output("ld_use_stat_load", stat_load_stalls, 32'd1);
    check_output("ld_use_stat_mul", stat_mul_stalls, 32'd0);
`endif
    drain();

    // Multi-cycle producer read on both operands
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, MUL);
    tick();
    apply_stimulus(1'b1, 5'd9, 5'd9, 2'b11, 5'd10, 1'b1, ALU);
    check_output("mul_stall1", 32'(bus.stall), 32'd1);
    tick();
    check_output("mul_stall2", 32'(bus.stall), 32'd1);
    tick();
    check_output("mul_stall3", 32'(bus.stall), 32'd0);
    tick();
    check_output("mul_sel", 32'(bus.ex_fwd_sel), 32'hF);
`ifdef FWD_STALL_STATS_EN
    check_output("mul_stat_mul", stat_mul_stalls, 32'd2);
    check_output("mul_stat_load", stat_load_stalls, 32'd1);
`endif
    drain();

    // Youngest writer wins, x0 never forwards, non-writers never match
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd4, 5'd0, 2'b11, 5'd11, 1'b1, ALU);
    check_output("youngest_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("youngest_sel", 32'(bus.ex_fwd_sel), 32'h1);
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, ALU);
    tick();
    apply_stimulus(1'b1, 5'd12, 5'd12, 2'b11, 5'd0, 1'b0, ALU);
    tick();
    check_output("no_regwrite_sel", 32'(bus.ex_fwd_sel), 32'd0);
    drain();

    // Deepest forwarding slot, then aged out to the register file
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd20, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd21, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, ALU);
    check_output("deep_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("deep_sel", 32'(bus.ex_fwd_sel), 32'h3);
    tick();
    check_output("aged_out_sel", 32'(bus.ex_fwd_sel), 32'd0);
    drain();

    // Load-use stall frozen by pipe_hold for four cycles
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, LD);
    tick();
    check_output("hold_pre_sel", 32'(bus.ex_fwd_sel), 32'h1);
    apply_stimulus(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, ALU);
    bus.pipe_hold = 1'b1;
    #1;
    check_output("hold_stall", 32'(bus.stall), 32'd1);
    for (int n = 0; n < 4; n++) begin
      tick();
      check_output("hold_frozen_stall", 32'(bus.stall), 32'd1);
      check_output("hold_frozen_sel", 32'(bus.ex_fwd_sel), 32'h1);
    end
    bus.pipe_hold = 1'b0;
    #1;
    check_output("hold_release_stall", 32'(bus.stall), 32'd1);
    tick();
    check_output("hold_bubble_sel", 32'(bus.ex_fwd_sel), 32'd0);
    check_output("hold_after_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("hold_fwd_sel", 32'(bus.ex_fwd_sel), 32'h2);
`ifdef FWD_STALL_STATS_EN
    check_output("hold_stat_load", stat_load_stalls, 32'd2);
`endif
    drain();

    // Flush beats a pending stall and inserts a bubble
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, LD);
    tick();
    apply_stimulus(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, ALU);
    check_output("flush_pre_stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    #1;
    check_output("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("flush_bubble_sel", 32'(bus.ex_fwd_sel), 32'd0);
    bus.flush = 1'b0;
    apply_stimulus(1'b1, 5'd7, 5'd8, 2'b11, 5'd0, 1'b0, ALU);
    check_output("flush_next_stall", 32'(bus.stall), 32'd0);
    tick();
    check_output("flush_next_sel", 32'(bus.ex_fwd_sel), 32'h2);
`ifdef FWD_STALL_STATS_EN
    check_output("flush_stat_load", stat_load_stalls, 32'd2);
`endif
    drain();

    // Asynchronous reset in the middle of a stall
    apply_stimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, ALU);
    tick();
    apply_stimulus(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, LD);
    tick();
    check_output("rst_pre_sel", 32'(bus.ex_fwd_sel), 32'h1);
    apply_stimulus(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, ALU);
    check_output("rst_pre_stall", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_async_stall", 32'(bus.stall), 32'd0);
    check_output("rst_async_sel", 32'(bus.ex_fwd_sel), 32'd0);
`ifdef FWD_STALL_STATS_EN
    check_output("rst_async_stat_load", stat_load_stalls, 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    check_output("rst_recover_sel", 32'(bus.ex_fwd_sel), 32'd0);
    check_output("rst_recover_stall", 32'(bus.stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
